apb_req_arbiter: RTL and testbench
==================================

// Module: apb_req_arbiter
// PURPOSE
//  Two-requester APB master. Shares one APB slave port (e.g. apb_slave_dummy or a register block)
//  between two request channels, such as the AXI4-Lite bridge front end and a debug/config port.
//  Round-robin arbitration; sequences the APB SETUP/ACCESS phases; handles pready wait states.
//  Returns a one-cycle response pulse with read data and a timeout error flag to the granted requester.
// PARAMETERS
//  ADDR_W   32  APB address width
//  DATA_W   32  APB data width
//  TIMEOUT  16  max ACCESS cycles without pready before error (>=2)
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  reset        in   1       synchronous, active-high reset
//  req0_valid   in   1       requester 0 has a transfer pending
//  req0_write   in   1       1=write, 0=read
//  req0_addr    in   ADDR_W  transfer address
//  req0_wdata   in   DATA_W  write data
//  req0_ready   out  1       accept strobe; transfer taken when valid&ready
//  rsp0_valid   out  1       one-cycle completion pulse for requester 0
//  rsp0_rdata   out  DATA_W  read data (0 for writes and on error)
//  rsp0_err     out  1       timeout error, qualified by rsp0_valid
//  req1_* / rsp1_*           identical set for requester 1
//  paddr        out  ADDR_W  APB address
//  psel         out  1       APB select
//  penable      out  1       APB enable
//  pwrite       out  1       APB direction
//  pwdata       out  DATA_W  APB write data
//  prdata       in   DATA_W  APB read data
//  pready       in   1       APB ready (wait-state insertion)
// BEHAVIOUR
//  FSM states: IDLE, SETUP, ACCESS, RESP.
//  IDLE: if any reqN_valid, grant one; reqN_ready=1 (combinational) only for the granted N, only in IDLE.
//    On valid&ready: latch addr/wdata/write into paddr/pwdata/pwrite and the grant id; go to SETUP.
//  Arbitration: if only one requester is valid, grant it. If both are valid, grant the one not
//    granted last. last_grant resets to 1, so requester 0 wins the first tie.
//  SETUP (1 cycle): psel=1, penable=0; clear timeout counter; go to ACCESS.
//  ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held stable.
//    pready=1: capture prdata (reads) or 0 (writes), err=0; go to RESP.
//    pready=0: increment counter. If the counter reaches TIMEOUT-1 with pready still low (TIMEOUT
//    ACCESS cycles in total), set err=1 and rdata=0, abandon the transfer, and go to RESP.
//  RESP (1 cycle): psel=0, penable=0; rspN_valid=1 for the granted N only, with rdata/err. Next state IDLE.
//  Response has no backpressure; requester must sink the pulse. rspN_rdata/err hold until the next response.
//  Latency (zero wait states): accept cycle T; SETUP T+1; ACCESS T+2; rsp_valid T+3; next accept T+4.
//    Each pready wait state adds 1 cycle.
//  req*_valid changes outside IDLE are ignored; no new grant until IDLE.
//  Reset values (synchronous, applied at next edge from any state): state=IDLE, psel=0, penable=0,
//    paddr=0, pwrite=0, pwdata=0, rsp*_valid=0, rsp*_rdata=0, rsp*_err=0, counter=0, last_grant=1.
//  Reset mid-transfer: in-flight transfer is dropped with no response; psel/penable low the cycle after reset.
//  psel never asserts in IDLE. penable only asserts in ACCESS.
// TESTING
//  1. req0 write 0x0000_0010 <- 0x1234_5678, then req1 read same addr (dummy slave)
//     -> rsp1_rdata=0x1234_5678, err=0; each transfer takes 4 cycles from accept.
//  2. Both valid right after reset, held -> grants 0,1,0,1; rsp pulses alternate; psel low 1 cycle between transfers.
//  3. Bench slave holds pready low 2 ACCESS cycles -> penable held 3 cycles; paddr/pwdata stable; rsp at accept+5.
//  4. TIMEOUT=4, pready stuck low -> exactly 4 ACCESS cycles; rsp0_valid with err=1, rdata=0; FSM back to IDLE.
//  5. reset asserted during ACCESS -> next cycle psel=penable=0; no rsp pulse; first tie after reset goes to req0.
//  6. req0 valid continuously, req1 idle -> req0_ready pulses every 4 cycles; req1_ready never asserts.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
//
// Two-requester APB master. Two request channels share one APB slave port.
// Arbitration is round-robin between requesters. The block sequences the
// APB SETUP/ACCESS phases and stretches ACCESS while pready is low. It returns
// a one-cycle response pulse, with read data and a timeout error flag, to the
// requester that owned the transfer.
//
// Parameters
//   ADDR_W   APB address width
//   DATA_W   APB data width
//   TIMEOUT  ACCESS cycles allowed without pready before the transfer is
//            abandoned with an error (must be >= 2)
//
// Ports
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   reqN_valid/write/addr/wdata   request channel N (N = 0, 1)
//   reqN_ready                    accept strobe; transfer taken on valid & ready
//   rspN_valid                    one-cycle completion pulse for requester N
//   rspN_rdata/err                completion data and timeout flag; held until
//                                 requester N's next response
//   paddr/psel/penable/pwrite/pwdata/prdata/pready   APB master port
// -----------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,

    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    // The wait counter only needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic                gnt_id_q, gnt_id_d;
    logic                last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rsp0_rdata_q, rsp0_rdata_d;
    logic                rsp0_err_q, rsp0_err_d;
    logic [DATA_W-1:0]   rsp1_rdata_q, rsp1_rdata_d;
    logic                rsp1_err_q, rsp1_err_d;

    logic                gnt_sel;
    logic                accept;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                done;
    logic [DATA_W-1:0]   done_rdata;
    logic                done_err;

    // Writes complete with zero read data.
    function automatic logic [DATA_W-1:0] read_result(input logic wr,
                                                      input logic [DATA_W-1:0] d);
        return wr ? '0 : d;
    endfunction

    // -------------------------------------------------------------------------
    // Arbitration: a lone requester wins outright; on a tie the requester that
    // was not granted last wins. last_grant resets to 1 so requester 0 takes the
    // first tie.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_sel = ~last_grant_q;
        end else if (req1_valid) begin
            gnt_sel = 1'b1;
        end
    end

    assign accept     = (state_q == S_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !gnt_sel;
    assign req1_ready = accept &&  gnt_sel;

    assign sel_write = gnt_sel ? req1_write : req0_write;
    assign sel_addr  = gnt_sel ? req1_addr  : req0_addr;
    assign sel_wdata = gnt_sel ? req1_wdata : req0_wdata;

    // -------------------------------------------------------------------------
    // Next state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pwrite_d     = pwrite_q;
        gnt_id_d     = gnt_id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp0_err_d   = rsp0_err_q;
        rsp1_rdata_d = rsp1_rdata_q;
        rsp1_err_d   = rsp1_err_q;
        done         = 1'b0;
        done_rdata   = '0;
        done_err     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    paddr_d      = sel_addr;
                    pwdata_d     = sel_wdata;
                    pwrite_d     = sel_write;
                    gnt_id_d     = gnt_sel;
                    last_grant_d = gnt_sel;
                    state_d      = S_SETUP;
                end
            end

            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_ACCESS;
            end

            S_ACCESS: begin
                if (pready) begin
                    done       = 1'b1;
                    done_rdata = read_result(pwrite_q, prdata);
                    done_err   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    // TIMEOUT ACCESS cycles without pready: give up on the slave.
                    done       = 1'b1;
                    done_rdata = '0;
                    done_err   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end

                if (done) begin
                    state_d = S_RESP;
                    if (gnt_id_q) begin
                        rsp1_rdata_d = done_rdata;
                        rsp1_err_d   = done_err;
                    end else begin
                        rsp0_rdata_d = done_rdata;
                        rsp0_err_d   = done_err;
                    end
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pwrite_q     <= 1'b0;
            gnt_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            rsp0_rdata_q <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_rdata_q <= '0;
            rsp1_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pwrite_q     <= pwrite_d;
            gnt_id_q     <= gnt_id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_rdata_q <= rsp1_rdata_d;
            rsp1_err_q   <= rsp1_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: APB phase strobes decode directly from the state, so they drop
    // the cycle after a reset regardless of where the transfer was.
    // -------------------------------------------------------------------------
    assign psel       = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign penable    = (state_q == S_ACCESS);
    assign paddr      = paddr_q;
    assign pwrite     = pwrite_q;
    assign pwdata     = pwdata_q;

    assign rsp0_valid = (state_q == S_RESP) && !gnt_id_q;
    assign rsp1_valid = (state_q == S_RESP) &&  gnt_id_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp0_err   = rsp0_err_q;
    assign rsp1_rdata = rsp1_rdata_q;
    assign rsp1_err   = rsp1_err_q;

    // Protocol invariants.
    a_penable_in_sel: assert property (@(posedge clk) disable iff (reset)
        penable |-> psel);
    a_one_rsp: assert property (@(posedge clk) disable iff (reset)
        !(rsp0_valid && rsp1_valid));
    a_one_ready: assert property (@(posedge clk) disable iff (reset)
        !(req0_ready && req1_ready));

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid, req0_write, req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid, rsp0_err;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              req1_valid, req1_write, req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid, rsp1_err;
    logic [DATA_W-1:0] rsp1_rdata;
    logic [ADDR_W-1:0] paddr;
    logic              psel, penable, pwrite, pready;
    logic [DATA_W-1:0] pwdata, prdata;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    apb_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: small memory, programmable wait states, optional stuck-low pready.
    logic [DATA_W-1:0] mem [0:63];
    int wait_cycles = 0;
    bit stuck = 1'b0;
    int acc_cnt = 0;

    assign pready = psel && penable && !stuck && (acc_cnt >= wait_cycles);
    assign prdata = mem[paddr[7:2]];

    always @(posedge clk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (psel && penable && pready && pwrite) mem[paddr[7:2]] <= pwdata;
    end

    // Scoreboard
    typedef struct {
        bit          id;
        logic [31:0] rdata;
        bit          err;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge clk) begin
        exp_t e;
        if (rsp0_valid || rsp1_valid) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL rsp_unexpected: rsp0_valid=%0b rsp1_valid=%0b, required no response",
                         rsp0_valid, rsp1_valid);
            end else begin
                e = exp_q.pop_front();
                if (rsp0_valid && rsp1_valid)
                    $display("FAIL rsp_both: both rsp pulses high, required only rsp%0d", e.id);
                else if (rsp1_valid !== e.id ||
                         (rsp1_valid ? rsp1_rdata : rsp0_rdata) !== e.rdata ||
                         (rsp1_valid ? rsp1_err : rsp0_err) !== e.err)
                    $display("FAIL rsp_data: got id=%0d rdata=%h err=%0b, required id=%0d rdata=%h err=%0b",
                             rsp1_valid, rsp1_valid ? rsp1_rdata : rsp0_rdata,
                             rsp1_valid ? rsp1_err : rsp0_err, e.id, e.rdata, e.err);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one request and waits (bounded) for its accept; acc = accept cycle or -1.
    task automatic do_xfer(input bit id, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input bit exp_err, input bit push, output int acc);
        exp_t e;
        acc = -1;
        if (id == 1'b0) begin
            req0_write = wr; req0_addr = addr; req0_wdata = wdata; req0_valid = 1'b1;
        end else begin
            req1_write = wr; req1_addr = addr; req1_wdata = wdata; req1_valid = 1'b1;
        end
        #1;
        for (int i = 0; i < 20; i++) begin
            if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
                acc = cyc;
                if (push) begin
                    e.id = id; e.rdata = exp_rdata; e.err = exp_err;
                    exp_q.push_back(e);
                end
                break;
            end
            @(negedge clk); #1;
        end
        @(negedge clk);
        if (id == 1'b0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
    endtask

    // Waits (bounded) for requester id's response pulse; rc = its cycle or -1.
    task automatic wait_rsp(input bit id, output int rc);
        rc = -1;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (id ? rsp1_valid : rsp0_valid) begin
                rc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_total++; if ({psel, penable, pwrite} !== 3'b000) $display("FAIL reset_ctl: psel/penable/pwrite=%b required 000", {psel, penable, pwrite}); else n_pass++;
        n_total++; if (paddr !== '0) $display("FAIL reset_paddr: got %h required 0", paddr); else n_pass++;
        n_total++; if (pwdata !== '0) $display("FAIL reset_pwdata: got %h required 0", pwdata); else n_pass++;
        n_total++; if ({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err} !== 4'b0000) $display("FAIL reset_rsp: valid/err=%b required 0000", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}); else n_pass++;
        n_total++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b required 00", {req0_ready, req1_ready}); else n_pass++;
    endtask

    task automatic test_write_read();
        int a0, a1, r0, r1;
        do_xfer(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, 1'b0, 1'b1, a0);
        n_total++; if (a0 < 0) $display("FAIL wr_accept: no accept, required accept"); else n_pass++;
        wait_rsp(1'b0, r0);
        n_total++; if (r0 !== a0 + 3) $display("FAIL wr_latency: rsp at %0d required %0d", r0, a0 + 3); else n_pass++;
        do_xfer(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0, 1'b1, a1);
        n_total++; if (a1 !== a0 + 4) $display("FAIL rd_accept: accept at %0d required %0d", a1, a0 + 4); else n_pass++;
        wait_rsp(1'b1, r1);
        n_total++; if (r1 !== a1 + 3) $display("FAIL rd_latency: rsp at %0d required %0d", r1, a1 + 3); else n_pass++;
    endtask

    task automatic test_round_robin();
        int   ng;
        int   acc [4];
        logic [3:0] grants;
        logic [3:0] psel_acc;
        exp_t e;
        int   rc;
        ng = 0; grants = '0; psel_acc = '1;
        do_reset();
        req0_write = 1'b1; req0_addr = 32'h20; req0_wdata = 32'hA5A5_0000;
        req1_write = 1'b0; req1_addr = 32'h10; req1_wdata = 32'h0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 30 && ng < 4; i++) begin
            #1;
            if (req0_ready || req1_ready) begin
                grants[3-ng]   = req1_ready;
                psel_acc[3-ng] = psel;
                acc[ng]        = cyc;
                e.id = req1_ready;
                e.rdata = req1_ready ? 32'h1234_5678 : 32'h0;
                e.err = 1'b0;
                exp_q.push_back(e);
                ng++;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_total++; if (ng !== 4) $display("FAIL rr_count: %0d grants, required 4", ng); else n_pass++;
        n_total++; if (grants !== 4'b0101) $display("FAIL rr_order: grants %b required 0101", grants); else n_pass++;
        n_total++; if (psel_acc !== 4'b0000) $display("FAIL rr_psel_idle: psel at accepts %b required 0000", psel_acc); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_total++; if (acc[k+1] - acc[k] !== 4) $display("FAIL rr_spacing: gap %0d required 4", acc[k+1] - acc[k]); else n_pass++;
        end
        wait_rsp(1'b1, rc);
        n_total++; if (rc !== acc[3] + 3) $display("FAIL rr_last_rsp: rsp at %0d required %0d", rc, acc[3] + 3); else n_pass++;
    endtask

    task automatic test_wait_states();
        int a, rc, pen, unstable;
        wait_cycles = 2;
        do_xfer(1'b0, 1'b1, 32'h30, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, a);
        pen = 0; unstable = 0; rc = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (penable) pen++;
            if (psel && (paddr !== 32'h30 || pwdata !== 32'hCAFE_F00D || pwrite !== 1'b1)) unstable++;
            if (rsp0_valid) begin rc = cyc; break; end
            @(negedge clk);
        end
        n_total++; if (pen !== 3) $display("FAIL ws_penable: %0d cycles required 3", pen); else n_pass++;
        n_total++; if (unstable !== 0) $display("FAIL ws_stable: %0d unstable cycles required 0", unstable); else n_pass++;
        n_total++; if (rc !== a + 5) $display("FAIL ws_latency: rsp at %0d required %0d", rc, a + 5); else n_pass++;
        do_xfer(1'b1, 1'b0, 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1, a);
        wait_rsp(1'b1, rc);
        n_total++; if (rc !== a + 5) $display("FAIL ws_rd_latency: rsp at %0d required %0d", rc, a + 5); else n_pass++;
        wait_cycles = 0;
    endtask

    task automatic test_timeout();
        int a, rc, pen;
        stuck = 1'b1;
        do_xfer(1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1, a);
        pen = 0; rc = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (penable) pen++;
            if (rsp0_valid) begin rc = cyc; break; end
            @(negedge clk);
        end
        stuck = 1'b0;
        n_total++; if (pen !== TIMEOUT) $display("FAIL to_access: %0d ACCESS cycles required %0d", pen, TIMEOUT); else n_pass++;
        n_total++; if (rc !== a + 6) $display("FAIL to_latency: rsp at %0d required %0d", rc, a + 6); else n_pass++;
        @(negedge clk); #1;
        n_total++; if ({rsp0_valid, rsp0_err, psel} !== 3'b010) $display("FAIL to_after: valid/err/psel=%b required 010", {rsp0_valid, rsp0_err, psel}); else n_pass++;
        do_xfer(1'b1, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0, 1'b1, a);
        n_total++; if (a !== rc + 1) $display("FAIL to_idle: accept at %0d required %0d", a, rc + 1); else n_pass++;
        wait_rsp(1'b1, rc);
    endtask

    task automatic test_reset_mid();
        int a, rc, nrsp;
        exp_t e;
        stuck = 1'b1;
        do_xfer(1'b0, 1'b1, 32'h50, 32'h0000_1111, 32'h0, 1'b0, 1'b0, a);
        @(negedge clk); #1;
        n_total++; if (penable !== 1'b1) $display("FAIL rm_in_access: penable=%b required 1", penable); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        stuck = 1'b0;
        #1;
        n_total++; if ({psel, penable} !== 2'b00) $display("FAIL rm_strobes: psel/penable=%b required 00", {psel, penable}); else n_pass++;
        n_total++; if (paddr !== '0 || pwdata !== '0) $display("FAIL rm_bus: paddr=%h pwdata=%h required 0", paddr, pwdata); else n_pass++;
        n_total++; if ({rsp0_err, rsp1_rdata} !== {1'b0, 32'h0}) $display("FAIL rm_rsp_regs: err0=%b rdata1=%h required 0", rsp0_err, rsp1_rdata); else n_pass++;
        nrsp = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (rsp0_valid || rsp1_valid) nrsp++;
        end
        n_total++; if (nrsp !== 0) $display("FAIL rm_no_rsp: %0d pulses required 0", nrsp); else n_pass++;
        req0_write = 1'b1; req0_addr = 32'h60; req0_wdata = 32'h0000_600D;
        req1_write = 1'b1; req1_addr = 32'h64; req1_wdata = 32'h0000_0064;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_total++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rm_tie: ready=%b required 10", {req0_ready, req1_ready}); else n_pass++;
        a = cyc;
        if (req0_ready) begin
            e.id = 1'b0; e.rdata = 32'h0; e.err = 1'b0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(1'b0, rc);
        n_total++; if (rc !== a + 3) $display("FAIL rm_rsp: rsp at %0d required %0d", rc, a + 3); else n_pass++;
    endtask

    task automatic test_single_stream();
        int   nacc, n1, rc;
        int   acc [8];
        exp_t e;
        nacc = 0; n1 = 0;
        req0_write = 1'b1; req0_addr = 32'h70; req0_wdata = 32'h0000_0077;
        req0_valid = 1'b1; req1_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (req1_ready) n1++;
            if (req0_ready && nacc < 8) begin
                acc[nacc] = cyc;
                nacc++;
                e.id = 1'b0; e.rdata = 32'h0; e.err = 1'b0;
                exp_q.push_back(e);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        n_total++; if (nacc !== 4) $display("FAIL ss_count: %0d accepts required 4", nacc); else n_pass++;
        n_total++; if (n1 !== 0) $display("FAIL ss_req1_ready: %0d cycles required 0", n1); else n_pass++;
        for (int k = 0; k + 1 < nacc && k < 3; k++) begin
            n_total++; if (acc[k+1] - acc[k] !== 4) $display("FAIL ss_spacing: gap %0d required 4", acc[k+1] - acc[k]); else n_pass++;
        end
        wait_rsp(1'b0, rc);
        n_total++; if (nacc < 1 || rc !== acc[nacc-1] + 3) $display("FAIL ss_last_rsp: rsp at %0d required accept+3", rc); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_single_stream();
        repeat (3) @(negedge clk);
        n_total++; if (exp_q.size() !== 0) $display("FAIL sb_drain: %0d responses outstanding required 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
